pll_lock_monitor: RTL and testbench
===================================

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 2700, clk cycles per measurement window (100 us at 27 MHz).
REQ-002 SHALL have parameter CNT_W, default 16, width of the edge counter and meas_count.
REQ-003 SHALL have parameter EXP_MIN, default 445, minimum in-range edge count per window.
REQ-004 SHALL have parameter EXP_MAX, default 455, maximum in-range edge count per window.
REQ-005 SHALL have parameter LOCK_COUNT, default 4, consecutive in-range windows needed to declare lock.
REQ-006 SHALL have parameter UNLOCK_COUNT, default 2, consecutive out-of-range windows needed to drop lock (hysteresis build only).
REQ-007 SHALL have the ports: clk  in  1  single clock for all logic, 27 MHz.
REQ-008 SHALL have the port: rst_n  in  1  asynchronous active-low reset.
REQ-009 SHALL have the port: en  in  1  monitor enable; low forces the monitor idle.
REQ-010 SHALL have the port: meas_toggle  in  1  asynchronous toggle from the monitored clock domain (clk72 / 16 gives 4.5 MHz edge rate).
REQ-011 SHALL have the port: clr_sticky  in  1  clears lost_sticky.
REQ-012 SHALL have the port: locked  out  1  registered lock indication.
REQ-013 SHALL have the port: meas_count  out  CNT_W  edges counted in the last evaluated window.
REQ-014 SHALL have the port: meas_valid  out  1  one-cycle pulse; meas_count just updated.
REQ-015 SHALL have the port: lost_sticky  out  1  set when locked falls, held until cleared.

Function
REQ-016 SHALL synchronize meas_toggle through 2 flops plus 1 history flop, and count both rising and falling edges (3-cycle input-to-count latency).
REQ-017 SHALL run a window counter 0..GATE_CYCLES-1 while en=1, wrapping to 0 after GATE_CYCLES-1.
REQ-018 SHALL, on the edge closing cycle GATE_CYCLES-1, load meas_count with the edge count plus any edge detected in that cycle, clear the edge count, and pulse meas_valid on the following cycle for exactly 1 cycle.
REQ-019 SHALL saturate the edge counter at 2^CNT_W-1, never wrapping it.
REQ-020 SHALL treat a window as in-range iff EXP_MIN <= meas_count <= EXP_MAX (inclusive, unsigned).
REQ-021 SHALL implement states UNLOCKED, ACQUIRE, LOCKED, SLIPPING.
REQ-022 SHALL transition UNLOCKED->ACQUIRE on an in-range window, with the good count set to 1.
REQ-023 SHALL, in ACQUIRE, increment the good count on each in-range window and enter LOCKED when it reaches LOCK_COUNT; any out-of-range window returns ACQUIRE->UNLOCKED.
REQ-024 SHALL update the state on the same edge that loads meas_count, and assert locked from the next cycle in LOCKED or SLIPPING.
REQ-025 SHALL treat the first window after reset release or after an en 0->1 transition as a discard window: no meas_valid pulse, no state update.
REQ-026 SHALL, while en=0, hold the window and edge counters at 0, force state UNLOCKED and locked=0, hold meas_count, and leave lost_sticky unchanged.
REQ-027 SHALL set lost_sticky on the cycle that locked goes 1->0 because of an out-of-range window; disabling via en SHALL NOT set it.
REQ-028 SHALL clear lost_sticky on clr_sticky=1, except that a set and a clear in the same cycle leaves it set.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: locked=0, meas_valid=0, lost_sticky=0, meas_count=0, state UNLOCKED, all counters and synchronizer flops 0.
REQ-030 SHALL deassert reset synchronously inside the block via a 2-flop reset release on clk.

Configuration
REQ-031 SHALL, with PLL_LOCK_MON_HYST_EN defined, on an out-of-range window go LOCKED->SLIPPING (bad count = 1).
REQ-032 SHALL, in SLIPPING with the hysteresis build, return to LOCKED on an in-range window, or enter UNLOCKED once UNLOCKUNT consecutive bad windows is reached.
REQ-033 SHALL, with PLL_LOCK_MON_HYST_EN undefined, go LOCKED->UNLOCKED on any single out-of-range window; SLIPPING is unreachable.

Verification
REQ-034 SHALL verify acquisition: 4.5 MHz edge stimulus, en=1 after reset -> discard window, then meas_count=450 each window; locked=1 one cycle after the 5th window end.
REQ-035 SHALL verify loss without the macro: locked, then one window at 300 edges -> locked=0 and lost_sticky=1 one cycle after that window's end.
REQ-036 SHALL verify hysteresis with the macro: locked, then windows of 300, 450 -> locked stays 1; then 300, 300 -> locked=0 after the second bad window.
REQ-037 SHALL verify boundaries: windows of exactly 445 and 455 -> in-range; windows of 444 and 456 -> out-of-range; frozen meas_toggle -> meas_count=0.
REQ-038 SHALL verify en/reset mid-operation: en=0 mid-window while locked -> locked=0 next cycle, lost_sticky unchanged; rst_n pulse mid-window -> all outputs 0 immediately.
REQ-039 SHALL verify sticky clearing: clr_sticky coincident with a lock-loss cycle -> lost_sticky=1; clr_sticky on the next cycle -> lost_sticky=0.

Source files
------------

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: counts both edges of a toggle from a monitored clock domain over
// fixed gate windows and tracks lock with an UNLOCKED/ACQUIRE/LOCKED/SLIPPING FSM.
// Build option: define PLL_LOCK_MON_HYST_EN to route out-of-range windows in LOCKED
// through SLIPPING (UNLOCK_COUNT bad windows drop lock); otherwise one bad window drops lock.
module pll_lock_monitor #(
    parameter int unsigned GATE_CYCLES  = 2700,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned EXP_MIN      = 445,
    parameter int unsigned EXP_MAX      = 455,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             meas_toggle,
    input  logic             clr_sticky,
    output logic             locked,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             lost_sticky
);
    localparam int unsigned WIN_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        SLIPPING = 2'd3
    } state_t;

    logic              rst_meta;
    logic              rst_sync_n;
    logic [2:0]        tog_sync;
    logic              edge_det;
    logic [WIN_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  win_total;
    logic              discard;
    logic              win_end;
    logic              eval;
    logic              in_range;
    state_t            state;
    state_t            state_nxt;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_nxt;
    logic [GOOD_W-1:0] good_inc;
    logic [BAD_W-1:0]  bad_cnt;
    logic [BAD_W-1:0]  bad_nxt;
    logic [BAD_W-1:0]  bad_inc;
    logic              lost_set;

    // Reset release: assert asynchronously, deassert after two clk edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    // Two-flop synchronizer for the toggle plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            tog_sync <= '0;
        end else begin
            tog_sync <= {tog_sync[1:0], meas_toggle};
        end
    end

    // Window bookkeeping and saturating edge total including this cycle's edge
    always_comb begin
        edge_det  = tog_sync[2] ^ tog_sync[1];
        win_end   = en && (win_cnt == WIN_W'(GATE_CYCLES - 1));
        eval      = win_end && !discard;
        win_total = (edge_det && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;
        in_range  = (win_total >= CNT_W'(EXP_MIN)) && (win_total <= CNT_W'(EXP_MAX));
        good_inc  = good_cnt + GOOD_W'(1);
        bad_inc   = bad_cnt + BAD_W'(1);
    end

    // Window/edge counters, measurement capture and the first-window discard flag
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            win_cnt    <= '0;
            edge_cnt   <= '0;
            discard    <= 1'b1;
            meas_count <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= eval;
            if (!en) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
                discard  <= 1'b1;
            end else if (win_end) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
                discard  <= 1'b0;
                if (!discard) begin
                    meas_count <= win_total;
                end
            end else begin
                win_cnt  <= win_cnt + WIN_W'(1);
                edge_cnt <= win_total;
            end
        end
    end

    // Lock FSM next state; only evaluated windows or disable change it
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        if (!en) begin
            state_nxt = UNLOCKED;
            good_nxt  = '0;
            bad_nxt   = '0;
        end else if (eval) begin
            case (state)
                UNLOCKED, ACQUIRE: begin
                    if (in_range) begin
                        if (32'(good_inc) >= LOCK_COUNT) begin
                            state_nxt = LOCKED;
                            good_nxt  = '0;
                        end else begin
                            state_nxt = ACQUIRE;
                            good_nxt  = good_inc;
                        end
                    end else begin
                        state_nxt = UNLOCKED;
                        good_nxt  = '0;
                    end
                end
                LOCKED: begin
                    if (!in_range) begin
`ifdef PLL_LOCK_MON_HYST_EN
                        if (UNLOCK_COUNT <= 1) begin
                            state_nxt = UNLOCKED;
                            bad_nxt   = '0;
                        end else begin
                            state_nxt = SLIPPING;
                            bad_nxt   = BAD_W'(1);
                        end
`else
                        state_nxt = UNLOCKED;
                        bad_nxt   = '0;
`endif
                    end
                end
                SLIPPING: begin
                    if (in_range) begin
                        state_nxt = LOCKED;
                        bad_nxt   = '0;
                    end else if (32'(bad_inc) >= UNLOCK_COUNT) begin
                        state_nxt = UNLOCKED;
                        bad_nxt   = '0;
                    end else begin
                        bad_nxt = bad_inc;
                    end
                end
                default: begin
                    state_nxt = UNLOCKED;
                    good_nxt  = '0;
                    bad_nxt   = '0;
                end
            endcase
        end
        lost_set = eval && ((state == LOCKED) || (state == SLIPPING)) && (state_nxt == UNLOCKED);
    end

    // FSM state, registered lock flag and lock-loss sticky (a set beats a clear)
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state       <= UNLOCKED;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            locked      <= 1'b0;
            lost_sticky <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            bad_cnt  <= bad_nxt;
            locked   <= (state_nxt == LOCKED) || (state_nxt == SLIPPING);
            if (lost_set) begin
                lost_sticky <= 1'b1;
            end else if (clr_sticky) begin
                lost_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: directed bench for pll_lock_monitor with default parameters.
// Window-aligned stimulus places a chosen number of toggles mid-window; honours
// PLL_LOCK_MON_HYST_EN for the lock-loss expectations.
module tb_pll_lock_monitor;
    localparam int GATE = 2700;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        meas_toggle;
    logic        clr_sticky;
    logic        locked;
    logic [15:0] meas_count;
    logic        meas_valid;
    logic        lost_sticky;

    int errors = 0;
    int checks = 0;

    pll_lock_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .meas_toggle (meas_toggle),
        .clr_sticky  (clr_sticky),
        .locked      (locked),
        .meas_count  (meas_count),
        .meas_valid  (meas_valid),
        .lost_sticky (lost_sticky)
    );

    always #5 clk = ~clk;

    // Drive window cycles [from,to): n toggles at cycles 10,15,...; clr_sticky high in cycle clr_at.
    // Entered and left on a negedge; cycle 0 is the cycle whose closing edge takes win_cnt 0->1.
    task automatic run_span(input int n, input int from, input int to, input int clr_at);
        for (int c = from; c < to; c++) begin
            if (c >= 10 && c < 10 + 5 * n && ((c - 10) % 5) == 0) meas_toggle = ~meas_toggle;
            clr_sticky = (c == clr_at);
            @(negedge clk);
        end
        clr_sticky = 1'b0;
    endtask

    task automatic run_window(input int n);
        run_span(n, 0, GATE, -1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; meas_toggle = 1'b0; clr_sticky = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_meas_valid: got %b expected 0", meas_valid); end
        checks++; if (lost_sticky !== 1'b0) begin errors++; $display("FAIL reset_lost_sticky: got %b expected 0", lost_sticky); end
        checks++; if (meas_count !== 16'd0) begin errors++; $display("FAIL reset_meas_count: got %0d expected 0", meas_count); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_acquire;
        en = 1'b1;
        run_window(450);
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL discard_valid: got %b expected 0", meas_valid); end
        checks++; if (meas_count !== 16'd0) begin errors++; $display("FAIL discard_count: got %0d expected 0", meas_count); end
        for (int w = 1; w <= 4; w++) begin
            run_window(450);
            checks++; if (meas_count !== 16'd450) begin errors++; $display("FAIL acq_count w%0d: got %0d expected 450", w, meas_count); end
            checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL acq_valid w%0d: got %b expected 1", w, meas_valid); end
            checks++; if (locked !== (w == 4)) begin errors++; $display("FAIL acq_locked w%0d: got %b expected %b", w, locked, (w == 4)); end
        end
    endtask

    task automatic test_en_disable;
        run_span(450, 0, 1, -1);
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: got %b expected 0", meas_valid); end
        run_span(450, 1, 1000, -1);
        en = 1'b0;
        @(negedge clk);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL en_off_locked: got %b expected 0", locked); end
        checks++; if (lost_sticky !== 1'b0) begin errors++; $display("FAIL en_off_sticky: got %b expected 0", lost_sticky); end
        checks++; if (meas_count !== 16'd450) begin errors++; $display("FAIL en_off_count_hold: got %0d expected 450", meas_count); end
        en = 1'b1;
        run_window(450);
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL en_rise_discard: got %b expected 0", meas_valid); end
        for (int w = 1; w <= 4; w++) begin
            run_window(450);
            checks++; if (locked !== (w == 4)) begin errors++; $display("FAIL relock w%0d: got %b expected %b", w, locked, (w == 4)); end
        end
    endtask

    task automatic test_loss;
`ifdef PLL_LOCK_MON_HYST_EN
        run_window(300);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hyst_bad1_locked: got %b expected 1", locked); end
        run_window(450);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hyst_good_locked: got %b expected 1", locked); end
        run_window(300);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL hyst_bad2_locked: got %b expected 1", locked); end
        checks++; if (lost_sticky !== 1'b0) begin errors++; $display("FAIL hyst_bad2_sticky: got %b expected 0", lost_sticky); end
`endif
        run_window(300);
        checks++; if (meas_count !== 16'd300) begin errors++; $display("FAIL loss_count: got %0d expected 300", meas_count); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_locked: got %b expected 0", locked); end
        checks++; if (lost_sticky !== 1'b1) begin errors++; $display("FAIL loss_sticky: got %b expected 1", lost_sticky); end
    endtask

    task automatic test_boundaries;
        int cnt [4];
        cnt = '{445, 455, 450, 455};
        for (int i = 0; i < 4; i++) begin
            run_window(cnt[i]);
            checks++; if (meas_count !== 16'(cnt[i])) begin errors++; $display("FAIL bnd_count %0d: got %0d expected %0d", i, meas_count, cnt[i]); end
            checks++; if (locked !== (i == 3)) begin errors++; $display("FAIL bnd_locked %0d: got %b expected %b", i, locked, (i == 3)); end
        end
        run_span(444, 0, 100, 5);
        checks++; if (lost_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky: got %b expected 0", lost_sticky); end
`ifdef PLL_LOCK_MON_HYST_EN
        run_span(444, 100, GATE, -1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL bnd_444_slip: got %b expected 1", locked); end
        run_span(444, 0, GATE, GATE - 1);
`else
        run_span(444, 100, GATE, GATE - 1);
`endif
        checks++; if (meas_count !== 16'd444) begin errors++; $display("FAIL bnd_444_count: got %0d expected 444", meas_count); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL bnd_444_locked: got %b expected 0", locked); end
        checks++; if (lost_sticky !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %b expected 1", lost_sticky); end
        run_span(450, 0, 1, 0);
        checks++; if (lost_sticky !== 1'b0) begin errors++; $display("FAIL clr_next_cycle: got %b expected 0", lost_sticky); end
        run_span(450, 1, GATE, -1);
        run_window(455);
        run_window(455);
        run_window(456);
        checks++; if (meas_count !== 16'd456) begin errors++; $display("FAIL bnd_456_count: got %0d expected 456", meas_count); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL bnd_456_locked: got %b expected 0", locked); end
        run_window(0);
        checks++; if (meas_count !== 16'd0) begin errors++; $display("FAIL frozen_count: got %0d expected 0", meas_count); end
        checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL frozen_valid: got %b expected 1", meas_valid); end
    endtask

    task automatic test_reset_mid;
        for (int w = 1; w <= 4; w++) run_window(450);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pre_reset_locked: got %b expected 1", locked); end
        run_span(450, 0, 1000, -1);
        rst_n = 1'b0;
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_reset_locked: got %b expected 0", locked); end
        checks++; if (meas_count !== 16'd0) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", meas_count); end
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", meas_valid); end
        checks++; if (lost_sticky !== 1'b0) begin errors++; $display("FAIL mid_reset_sticky: got %b expected 0", lost_sticky); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_en_disable();
        test_loss();
        test_boundaries();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
